// File: rtl/gmem_pattern_loader_pkg.sv
// Shared types and helpers for the global-memory pattern loader.
// The pattern for lane j of beat k is 32'hFFFFFFFF + (k+1)*2*j, modulo 2^32.
package gmem_pattern_loader_pkg;

  localparam int PKG_DATA_W = 256;
  localparam int LANES      = PKG_DATA_W / 32;
  localparam int BEAT_BYTES = PKG_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_DRAIN,
    DONE
  } state_t;

  function automatic logic [31:0] pattern_lane(input logic [31:0] k, input logic [31:0] j);
    pattern_lane = 32'hFFFF_FFFF + (k + 32'd1) * (j << 1);
  endfunction

endpackage

// File: rtl/gmem_pattern_gen.sv
// Incremental pattern generator: clear loads beat 0, each advance steps to the next beat.
// Every lane adds a fixed 2*j per step, so no multiplier is needed at run time.
module gmem_pattern_gen
  import gmem_pattern_loader_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] beat
);

  localparam int NL = DATA_W / 32;

  logic [31:0] lane_q [NL];
  logic [31:0] lane_d [NL];

  always_comb begin
    for (int j = 0; j < NL; j++) begin
      lane_d[j] = lane_q[j];
      if (clear) begin
        lane_d[j] = pattern_lane(32'd0, 32'(j));
      end else if (advance) begin
        lane_d[j] = lane_q[j] + 32'(2 * j);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int j = 0; j < NL; j++) lane_q[j] <= '0;
    end else begin
      for (int j = 0; j < NL; j++) lane_q[j] <= lane_d[j];
    end
  end

  always_comb begin
    for (int j = 0; j < NL; j++) beat[j*32 +: 32] = lane_q[j];
  end

endmodule

// File: rtl/gmem_pattern_loader.sv
// Avalon-MM master that fills a memory region with the test pattern and
// optionally reads it back, counting mismatching beats.
module gmem_pattern_loader
  import gmem_pattern_loader_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int BEATS_W     = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [BEATS_W-1:0]    num_beats,
  input  logic                  verify_en,
  output logic                  busy,
  output logic                  done,
  output logic [BEATS_W-1:0]    err_cnt,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_burstcount,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int STRIDE = DATA_W / 8;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [BEATS_W-1:0] ONE_BEAT = BEATS_W'(1);
  localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0]  PEND_ONE = PEND_W'(1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [BEATS_W-1:0]   num_q, num_d;
  logic                 verify_q, verify_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BEATS_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [BEATS_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic [BEATS_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]    first_err_q, first_err_d;
  logic [ADDR_W-1:0]    cmp_addr_q, cmp_addr_d;

  logic                 gen_clear;
  logic                 wr_acc;
  logic                 rd_req;
  logic                 rd_acc;
  logic                 rdv;
  logic [DATA_W-1:0]    wr_beat;
  logic [DATA_W-1:0]    cmp_beat;

  // Read data is only meaningful while reads can be outstanding; anything else is stale.
  assign wr_acc = (state_q == WRITE) && !avm_waitrequest;
  assign rd_req = (state_q == RD_ISSUE) && (pend_q < PEND_MAX);
  assign rd_acc = rd_req && !avm_waitrequest;
  assign rdv    = avm_readdatavalid && ((state_q == RD_ISSUE) || (state_q == RD_DRAIN));

  gmem_pattern_gen #(.DATA_W(DATA_W)) u_wr_gen (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (gen_clear),
    .advance (wr_acc),
    .beat    (wr_beat)
  );

  gmem_pattern_gen #(.DATA_W(DATA_W)) u_cmp_gen (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (gen_clear),
    .advance (rdv),
    .beat    (cmp_beat)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    verify_d    = verify_q;
    addr_d      = addr_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    pend_d      = pend_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    cmp_addr_d  = cmp_addr_q;
    gen_clear   = 1'b0;
    avm_write   = 1'b0;
    avm_read    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          num_d       = num_beats;
          verify_d    = verify_en;
          addr_d      = base_addr;
          cmp_addr_d  = base_addr;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          pend_d      = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          gen_clear   = 1'b1;
          state_d     = (num_beats == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        avm_write = 1'b1;
        if (wr_acc) begin
          wr_cnt_d = wr_cnt_q + ONE_BEAT;
          if (wr_cnt_q == num_q - ONE_BEAT) begin
            addr_d  = base_q;
            state_d = verify_q ? RD_ISSUE : DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(STRIDE);
          end
        end
      end
      RD_ISSUE: begin
        avm_read = rd_req;
        if (rd_acc) begin
          rd_cnt_d = rd_cnt_q + ONE_BEAT;
          addr_d   = addr_q + ADDR_W'(STRIDE);
          if (rd_cnt_q == num_q - ONE_BEAT) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (pend_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stray valid with nothing outstanding must not wrap the counter.
    if (rd_acc && !rdv) begin
      pend_d = pend_q + PEND_ONE;
    end else if (!rd_acc && rdv && (pend_q != '0)) begin
      pend_d = pend_q - PEND_ONE;
    end

    if (rdv) begin
      cmp_addr_d = cmp_addr_q + ADDR_W'(STRIDE);
      if (avm_readdata != cmp_beat) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ONE_BEAT;
        if (err_cnt_q == '0) first_err_d = cmp_addr_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      verify_q    <= 1'b0;
      addr_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      pend_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      verify_q    <= verify_d;
      addr_q      <= addr_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pend_q      <= pend_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign busy           = (state_q == WRITE) || (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
  assign done           = (state_q == DONE);
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wr_beat;
  assign avm_byteenable = '1;
  assign avm_burstcount = 1'b1;

endmodule

// File: tb/tb_gmem_pattern_loader.sv
// Scoreboard bench for gmem_pattern_loader: stimulus pushes expected writes, reads and
// completion results; a negedge monitor pops and compares them as the DUT presents them.
module tb_gmem_pattern_loader;
  import gmem_pattern_loader_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int BW = 16;
  localparam int MP = 8;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [BW-1:0]   num_beats = '0;
  logic            verify_en = 1'b0;
  logic            busy;
  logic            done;
  logic [BW-1:0]   err_cnt;
  logic [AW-1:0]   first_err_addr;
  logic [AW-1:0]   avm_address;
  logic            avm_write;
  logic            avm_read;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_burstcount;
  logic            avm_waitrequest = 1'b0;
  logic [DW-1:0]   avm_readdata = '0;
  logic            avm_readdatavalid = 1'b0;

  always #5 clock = ~clock;

  gmem_pattern_loader #(
    .ADDR_W(AW), .DATA_W(DW), .BEATS_W(BW), .MAX_PENDING(MP)
  ) dut (
    .clock             (clock),
    .resetn            (resetn),
    .start             (start),
    .base_addr         (base_addr),
    .num_beats         (num_beats),
    .verify_en         (verify_en),
    .busy              (busy),
    .done              (done),
    .err_cnt           (err_cnt),
    .first_err_addr    (first_err_addr),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [BW-1:0] err; logic [AW-1:0] addr; } done_t;
  typedef struct { int due; logic [DW-1:0] data; } ret_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  done_t         exp_done[$];
  ret_t          ret_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int            wait_mode = 0;
  int            rd_lat = 1;
  int            cor0 = -1;
  int            cor1 = -1;
  logic [AW-1:0] cur_base = '0;
  int            cyc = 0;

  int            wr_seen, rd_seen, outstanding, max_out;
  int            last_wr_cyc, done_cyc, start_cyc;
  logic          b2b_chk = 1'b0;
  logic [DW-1:0] first_wdata, last_wdata;
  logic [AW-1:0] last_waddr;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Reference pattern straight from the closed-form definition.
  function automatic logic [DW-1:0] expBeat(input int k);
    logic [DW-1:0] b;
    for (int j = 0; j < LANES; j++) b[j*32 +: 32] = 32'hFFFF_FFFF + 32'((k + 1) * 2 * j);
    return b;
  endfunction

  // Slave model: drives waitrequest/readdatavalid just after each rising edge,
  // stores accepted writes and queues read returns with a fixed latency.
  always @(posedge clock) begin
    ret_t          r;
    logic [DW-1:0] d;
    int            k;
    #1;
    cyc++;
    avm_readdatavalid = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata = r.data;
    end
    avm_waitrequest = (wait_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (avm_write && !avm_waitrequest) mem[avm_address] = avm_writedata;
    if (avm_read && !avm_waitrequest && resetn) begin
      d = mem.exists(avm_address) ? mem[avm_address] : '0;
      k = int'((avm_address - cur_base) / BEAT_BYTES);
      if (k == cor0 || k == cor1) d = d ^ {{(DW-1){1'b0}}, 1'b1};
      r.due = cyc + rd_lat;
      r.data = d;
      ret_q.push_back(r);
    end
  end

  // Monitor: compares every bus acceptance and completion against the scoreboard.
  always @(negedge clock) begin
    logic          stall_wr, stall_rd;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    wr_t           w;
    logic [AW-1:0] ra;
    done_t         dn;
    if (!resetn) begin
      stall_wr = 1'b0;
      stall_rd = 1'b0;
      outstanding = 0;
    end else begin
      if (stall_wr) begin
        checkOutput("stall_write_held", DW'(avm_write), DW'(1));
        checkOutput("stall_addr", DW'(avm_address), DW'(p_addr));
        checkOutput("stall_data", avm_writedata, p_data);
      end
      if (stall_rd) begin
        checkOutput("stall_read_held", DW'(avm_read), DW'(1));
        checkOutput("stall_rd_addr", DW'(avm_address), DW'(p_addr));
      end
      stall_wr = avm_write && avm_waitrequest;
      stall_rd = avm_read && avm_waitrequest;
      p_addr = avm_address;
      p_data = avm_writedata;

      if (avm_write && !avm_waitrequest) begin
        if (exp_wr.size() == 0) begin
          failNow("unexpected_write");
        end else begin
          w = exp_wr.pop_front();
          checkOutput("wr_addr", DW'(avm_address), DW'(w.addr));
          checkOutput("wr_data", avm_writedata, w.data);
        end
        if (b2b_chk && wr_seen > 0) checkOutput("wr_back2back", DW'(cyc - last_wr_cyc), DW'(1));
        if (wr_seen == 0) first_wdata = avm_writedata;
        last_wdata = avm_writedata;
        last_waddr = avm_address;
        last_wr_cyc = cyc;
        wr_seen++;
      end

      if (avm_read && !avm_waitrequest) begin
        if (exp_rd.size() == 0) begin
          failNow("unexpected_read");
        end else begin
          ra = exp_rd.pop_front();
          checkOutput("rd_addr", DW'(avm_address), DW'(ra));
        end
        checkOutput("pending_limit", DW'(outstanding < MP), DW'(1));
        rd_seen++;
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
      end
      if (avm_readdatavalid && outstanding > 0) outstanding--;

      if (done) begin
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          failNow("unexpected_done");
        end else begin
          dn = exp_done.pop_front();
          checkOutput("err_cnt", DW'(err_cnt), DW'(dn.err));
          checkOutput("first_err_addr", DW'(first_err_addr), DW'(dn.addr));
          checkOutput("busy_at_done", DW'(busy), DW'(0));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] base, input int n, input logic ver,
                               input int wmode, input int lat, input int c0, input int c1,
                               input logic [BW-1:0] e_err, input logic [AW-1:0] e_first);
    wr_t   w;
    done_t dn;
    wait_mode = wmode;
    rd_lat = lat;
    cor0 = c0;
    cor1 = c1;
    cur_base = base;
    for (int k = 0; k < n; k++) begin
      w.addr = base + AW'(k * BEAT_BYTES);
      w.data = expBeat(k);
      exp_wr.push_back(w);
      if (ver) exp_rd.push_back(w.addr);
    end
    dn.err = e_err;
    dn.addr = e_first;
    exp_done.push_back(dn);
    wr_seen = 0;
    rd_seen = 0;
    max_out = 0;
    @(negedge clock);
    base_addr = base;
    num_beats = BW'(n);
    verify_en = ver;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic flushScoreboard();
    exp_wr.delete();
    exp_rd.delete();
    exp_done.delete();
  endtask

  task automatic waitDone(input string name);
    for (int t = 0; t < 20000 && exp_done.size() != 0; t++) @(negedge clock);
    if (exp_done.size() != 0) begin
      checkOutput({name, "_timeout"}, DW'(0), DW'(1));
      flushScoreboard();
    end
    checkOutput({name, "_writes_left"}, DW'(exp_wr.size()), DW'(0));
    checkOutput({name, "_reads_left"}, DW'(exp_rd.size()), DW'(0));
    repeat (2) @(negedge clock);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_busy"}, DW'(busy), DW'(0));
    checkOutput({name, "_done"}, DW'(done), DW'(0));
    checkOutput({name, "_write"}, DW'(avm_write), DW'(0));
    checkOutput({name, "_read"}, DW'(avm_read), DW'(0));
    checkOutput({name, "_err_cnt"}, DW'(err_cnt), DW'(0));
    checkOutput({name, "_first_err"}, DW'(first_err_addr), DW'(0));
    checkOutput({name, "_address"}, DW'(avm_address), DW'(0));
    checkOutput({name, "_writedata"}, avm_writedata, DW'(0));
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checkResetState("reset");
    checkOutput("byteenable", DW'(avm_byteenable), DW'({(DW/8){1'b1}}));
    checkOutput("burstcount", DW'(avm_burstcount), DW'(1));
    resetn = 1'b1;
    @(negedge clock);

    $display("[TB] short write, no verify");
    b2b_chk = 1'b1;
    applyStimulus(32'h0, 4, 1'b0, 0, 1, -1, -1, 16'd0, 32'h0);
    waitDone("t1");
    b2b_chk = 1'b0;
    checkOutput("t1_count", DW'(wr_seen), DW'(4));
    checkOutput("t1_reads", DW'(rd_seen), DW'(0));
    checkOutput("t1_beat0_lane0", DW'(first_wdata[31:0]), DW'(32'hFFFF_FFFF));
    checkOutput("t1_beat0_lane1", DW'(first_wdata[63:32]), DW'(32'h0000_0001));
    checkOutput("t1_beat0_lane2", DW'(first_wdata[95:64]), DW'(32'h0000_0003));
    checkOutput("t1_beat3_lane7", DW'(last_wdata[255:224]), DW'(32'h0000_0037));
    checkOutput("t1_last_addr", DW'(last_waddr), DW'(32'h60));
    checkOutput("t1_done_latency", DW'(done_cyc - last_wr_cyc), DW'(1));

    $display("[TB] long region, random stalls, verify, start while busy");
    applyStimulus(32'h0040_0000, 256, 1'b1, 1, 1, -1, -1, 16'd0, 32'h0);
    repeat (20) @(negedge clock);
    base_addr = 32'h0080_0000;
    num_beats = 16'd5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone("t2");
    checkOutput("t2_count", DW'(wr_seen), DW'(256));
    checkOutput("t2_reads", DW'(rd_seen), DW'(256));
    checkOutput("t2_last_addr", DW'(last_waddr), DW'(32'h0040_1FE0));

    $display("[TB] verify with slow read returns");
    applyStimulus(32'h0000_8000, 16, 1'b1, 0, 10, -1, -1, 16'd0, 32'h0);
    waitDone("t3");
    checkOutput("t3_max_pending", DW'(max_out), DW'(MP));
    checkOutput("t3_reads", DW'(rd_seen), DW'(16));

    $display("[TB] verify with corrupted beats 5 and 9");
    applyStimulus(32'h0000_1000, 16, 1'b1, 0, 3, 5, 9, 16'd2, 32'h0000_10A0);
    waitDone("t4");
    repeat (4) @(negedge clock);
    checkOutput("t4_err_hold", DW'(err_cnt), DW'(2));
    checkOutput("t4_first_hold", DW'(first_err_addr), DW'(32'h0000_10A0));

    $display("[TB] zero beats");
    applyStimulus(32'h0000_5000, 0, 1'b1, 0, 1, -1, -1, 16'd0, 32'h0);
    waitDone("t5");
    checkOutput("t5_done_latency", DW'(done_cyc - start_cyc), DW'(1));
    checkOutput("t5_writes", DW'(wr_seen), DW'(0));
    checkOutput("t5_reads", DW'(rd_seen), DW'(0));

    $display("[TB] reset during read issue");
    applyStimulus(32'h0000_2000, 16, 1'b1, 0, 10, -1, -1, 16'd0, 32'h0);
    for (int t = 0; t < 2000 && outstanding < 3; t++) @(negedge clock);
    checkOutput("t6_reached_three", DW'(outstanding >= 3), DW'(1));
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    flushScoreboard();
    checkResetState("t6_reset");
    resetn = 1'b1;
    repeat (15) @(negedge clock);
    checkOutput("t6_err_after_late", DW'(err_cnt), DW'(0));
    checkOutput("t6_busy_after_late", DW'(busy), DW'(0));
    applyStimulus(32'h0000_3000, 8, 1'b1, 0, 2, -1, -1, 16'd0, 32'h0);
    waitDone("t6_restart");
    checkOutput("t6_restart_writes", DW'(wr_seen), DW'(8));

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmem_pattern_loader.md
Name: gmem_pattern_loader

Overview:
- Synthesizable Avalon-MM master that loads global memory with a deterministic 256-bit test pattern through the host bridge of the on-chip RAM, then optionally reads it back and checks it.
- Sits directly upstream of the global-memory host port. It replaces the task-driven host writes, so kernel runs can start from known data on hardware as well as in simulation.
- The controlling agent pulses start once per region. The loader reports done, an error count and the address of the first mismatch.

Parameters:
- ADDR_W, 32, Avalon address width (byte address).
- DATA_W, 256, Avalon data width; must be a multiple of 32.
- BEATS_W, 16, width of the beat-count input.
- MAX_PENDING, 8, maximum outstanding reads during verify; power of two, ≥1.

Ports:
- clock  in  1  Single clock for all logic.
- resetn  in  1  Synchronous reset, active-low.
- start  in  1  One-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  First byte address; must be DATA_W/8 aligned.
- num_beats  in  BEATS_W  Number of DATA_W beats to write.
- verify_en  in  1  1 = read back and compare after writing.
- busy  out  1  High from the cycle after an accepted start until done.
- done  out  1  One-cycle pulse at completion.
- err_cnt  out  BEATS_W  Count of mismatching beats, saturating.
- first_err_addr  out  ADDR_W  Address of the first mismatching beat.
- avm_address  out  ADDR_W  Avalon address.
- avm_write  out  1  Avalon write.
- avm_read  out  1  Avalon read.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_byteenable  out  DATA_W/8  Tied all-ones.
- avm_burstcount  out  1  Tied 1.
- avm_waitrequest  in  1  Slave stall.
- avm_readdata  in  DATA_W  Read data.
- avm_readdatavalid  in  1  Read data valid.

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE. busy, done, avm_write, avm_read, err_cnt, first_err_addr, avm_address and avm_writedata all 0. Pending counter cleared.
- Reset mid-operation abandons the transfer at once. Any readdatavalid arriving afterwards is ignored, because readdatavalid is ignored outside RD_ISSUE/RD_DRAIN.
- Pattern definition:
  - Lane j (32 bits, j=0..DATA_W/32-1) of beat k (k=0..num_beats-1) = 32'hFFFFFFFF + (k+1)*2*j, modulo 2^32.
  - Beat 0 is therefore lane0=FFFFFFFF, lane1=00000001, lane2=00000003, and so on.
  - The generator restarts at every accepted start. Beat address = base_addr + k*(DATA_W/8), wrapping modulo 2^ADDR_W.
- States:
  - IDLE: on start=1, latch the inputs and clear err_cnt and first_err_addr. If num_beats=0, go to DONE with no bus activity. Otherwise go to WRITE.
  - WRITE: avm_write=1 with address and data for beat k. While avm_waitrequest=1, hold address, data and write stable. The beat is accepted on a cycle with write=1 and waitrequest=0; the next beat is presented the following cycle (back-to-back, no idle gap). After the last beat is accepted, go to RD_ISSUE if verify_en, otherwise DONE.
  - RD_ISSUE: avm_read=1 only while pending<MAX_PENDING. Address is held under waitrequest. A read is accepted when read=1 and waitrequest=0, which increments pending. After the last read is accepted, go to RD_DRAIN.
  - RD_DRAIN: wait until pending=0, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Pending counter:
  - A readdatavalid decrements pending. An acceptance and a readdatavalid in the same cycle leave pending unchanged.
  - Readdatavalid is legal in RD_ISSUE as well as RD_DRAIN.
- Compare:
  - A second generator instance advances per readdatavalid; read data returns in order.
  - On a mismatch: err_cnt increments, saturating at all-ones. first_err_addr is loaded only when err_cnt was 0.
- Outputs are valid once done pulses and are held until the next accepted start.
- start while busy is ignored. start in the same cycle as done is ignored.

Decomposition:
- Package gmem_pattern_loader_pkg holds:
  - state enum (IDLE, WRITE, RD_ISSUE, RD_DRAIN, DONE);
  - localparams LANES=DATA_W/32 and BEAT_BYTES=DATA_W/8;
  - function pattern_lane(k, j).
- Sub-module gmem_pattern_gen: clock, resetn, clear, advance, DATA_W beat output. It holds per-lane registers, each adding 2*j per advance; no multiplier. It is instantiated twice: write generator and compare generator.

Test Plan:
- base=0x0, num_beats=4, verify_en=0, waitrequest=0 → writes at 0x00/0x20/0x40/0x60 on consecutive cycles. Beat 3 lane7 = FFFFFFFF+56 = 0x00000037. done pulses 1 cycle after the last write; no reads.
- base=0x400000, num_beats=256, waitrequest random 50% → exactly 256 accepted writes, last at 0x401FE0, data stable across every stall, err_cnt=0 after verify.
- verify_en=1, num_beats=16, MAX_PENDING=8, slave returns data 10 cycles after accept → pending never exceeds 8, read stalls observed, err_cnt=0.
- verify with the slave corrupting beats 5 and 9 → err_cnt=2, first_err_addr = base+0xA0.
- num_beats=0 → done 1 cycle after start, no avm_write/avm_read asserted. start pulsed while busy → ignored, transfer count unchanged.
- resetn low during RD_ISSUE with 3 reads outstanding, late readdatavalid → all outputs 0, err_cnt stays 0. A fresh start then completes normally.
